// File: rtl/ka_pkg.sv
// Shared types, sizes and overlap-placement helper for the 16-bit sequential Karatsuba multiplier.
package ka_pkg;

  localparam int unsigned KA16_N  = 16;
  localparam int unsigned KA16_H  = KA16_N / 2;
  localparam int unsigned KA16_PW = 2 * KA16_N - 1;
  localparam int unsigned KA16_HW = 2 * KA16_H - 1;
  localparam int unsigned KA16_CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MID,
    DONE
  } ka_state_e;

  typedef struct packed {
    logic [KA16_N-1:0] a;
    logic [KA16_N-1:0] b;
  } ka_operands_t;

  // Place low/middle/high partial products at offsets 0, H and N, overlapping by XOR.
  function automatic logic [KA16_PW-1:0] ka_overlap(
    input logic [KA16_HW-1:0] p0,
    input logic [KA16_HW-1:0] m,
    input logic [KA16_HW-1:0] p2
  );
    return KA16_PW'(p0) ^ (KA16_PW'(m) << KA16_H) ^ (KA16_PW'(p2) << KA16_N);
  endfunction

endpackage

// File: rtl/clmul8.sv
// Combinational H x H carry-less (GF(2)[x]) multiplier; shared across all three Karatsuba sub-products.
module clmul8
  import ka_pkg::*;
(
  input  logic [KA16_H-1:0]  a_i,
  input  logic [KA16_H-1:0]  b_i,
  output logic [KA16_HW-1:0] prod_o_c
);

  always_comb begin
    prod_o_c = '0;
    for (int unsigned i = 0; i < KA16_H; i++) begin
      if (b_i[i]) begin
        prod_o_c = prod_o_c ^ (KA16_HW'(a_i) << i);
      end
    end
  end

endmodule

// File: rtl/ka16_seq_mult.sv
// Sequential 16-bit carry-less Karatsuba multiplier: one shared 8x8 clmul stepped through LO/HI/MID.
// Optional completed-product counter on port op_count when KA16_OPCNT_EN is defined.
module ka16_seq_mult
  import ka_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KA16_N-1:0]   a_in,
  input  logic [KA16_N-1:0]   b_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [KA16_PW-1:0]  p_out,
  output logic                busy
`ifdef KA16_OPCNT_EN
  ,
  output logic [KA16_CW-1:0]  op_count
`endif
);

  ka_state_e           state_q, state_d;
  ka_operands_t        ops_q, ops_d;
  logic [KA16_HW-1:0]  p0_q, p0_d;
  logic [KA16_HW-1:0]  p2_q, p2_d;
  logic [KA16_PW-1:0]  p_out_q, p_out_d;

  logic [KA16_H-1:0]   mul_a, mul_b;
  logic [KA16_HW-1:0]  mul_p;

  // Operand select for the shared multiplier; idle states park it at zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      LO: begin
        mul_a = ops_q.a[KA16_H-1:0];
        mul_b = ops_q.b[KA16_H-1:0];
      end
      HI: begin
        mul_a = ops_q.a[KA16_N-1:KA16_H];
        mul_b = ops_q.b[KA16_N-1:KA16_H];
      end
      MID: begin
        mul_a = ops_q.a[KA16_H-1:0] ^ ops_q.a[KA16_N-1:KA16_H];
        mul_b = ops_q.b[KA16_H-1:0] ^ ops_q.b[KA16_N-1:KA16_H];
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  clmul8 u_clmul8 (
    .a_i      (mul_a),
    .b_i      (mul_b),
    .prod_o_c (mul_p)
  );

  // Next-state, handshake and datapath-load decode.
  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    p0_d     = p0_q;
    p2_d     = p2_q;
    p_out_d  = p_out_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ops_d   = '{a: a_in, b: b_in};
          state_d = LO;
        end
      end
      LO: begin
        p0_d    = mul_p;
        state_d = HI;
      end
      HI: begin
        p2_d    = mul_p;
        state_d = MID;
      end
      MID: begin
        p_out_d = ka_overlap(p0_q, mul_p ^ p0_q ^ p2_q, p2_q);
        state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            ops_d   = '{a: a_in, b: b_in};
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ops_q   <= '0;
      p0_q    <= '0;
      p2_q    <= '0;
      p_out_q <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      p0_q    <= p0_d;
      p2_q    <= p2_d;
      p_out_q <= p_out_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p_out     = p_out_q;

`ifdef KA16_OPCNT_EN
  logic                out_hs;
  logic [KA16_CW-1:0]  op_count_q, op_count_d;

  assign out_hs     = (state_q == DONE) && out_ready;
  assign op_count_d = out_hs ? op_count_q + KA16_CW'(1) : op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: doc/ka16_seq_mult.md
# ka16_seq_mult

Sequential 16-bit binary-field (carry-less, GF(2)[x]) Karatsuba multiplier controller. It time-shares one 8×8 carry-less multiplier across the three Karatsuba sub-products (low, high, middle) and recombines them into the 31-bit product using overlap-XOR placement at offsets 0/8/16. It sits between an operand source and the 233-bit KA tree as a small-area alternative to the fully parallel 16-bit stage. Valid/ready handshakes are used on both sides.

## Interface
- N, 16, operand width; must be even; H = N/2 is the shared-multiplier width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a_in  in  N  operand A, bit i = coefficient of x^i
- b_in  in  N  operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p_out  out  2N-1  carry-less product A·B
- busy  out  1  high in any state other than IDLE
- op_count  out  16  completed-product counter (only with KA16_OPCNT_EN)

## Operation
- States: IDLE, LO, HI, MID, DONE.
- IDLE: in_ready=1. A handshake (in_valid&&in_ready) latches a_in/b_in into a_r/b_r and moves the state to LO.
- LO: the shared multiplier computes aL·bL (bits H-1:0). The result is registered into p0 (2H-1 bits). Next state is HI.
- HI: the multiplier computes aH·bH. The result is registered into p2. Next state is MID.
- MID: the multiplier computes (aL^aH)·(bL^bH) = pm.
  - In the same edge, p_out is loaded with p0 ^ ((pm^p0^p2) << H) ^ (p2 << N), truncated to 2N-1 bits.
  - Next state is DONE.
- Overlap rule for N=16:
  - bits 7:0 = p0[7:0]
  - bits 14:8 = p0[14:8]^m[6:0]
  - bit 15 = m[7]
  - bits 22:16 = m[14:8]^p2[6:0]
  - bits 30:23 = p2[14:7]
  - where m = pm^p0^p2.
- DONE: out_valid=1 and p_out is held stable.
  - Output handshake with no input handshake: next state is IDLE.
  - Output handshake with input handshake in the same cycle: new operands are latched and next state is LO (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Multiplier input mux is selected by state. In IDLE/DONE it is driven with zeros (no toggling).
- All arithmetic is XOR/AND only. There are no carries.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0
  - p_out=0, a_r/b_r/p0/p2=0, op_count=0
- Latency: input handshake at edge E0 gives out_valid=1 after edge E3 (3 cycles).
- Throughput: 1 product per 4 cycles with out_ready held high; 1 per 5 cycles with IDLE gaps.
- Backpressure: with out_ready=0 in DONE, p_out and out_valid hold indefinitely and in_ready=0.
- in_valid while busy (not DONE with out_ready) is ignored. Operands are not captured and there is no error.
- Reset asserted mid-operation (any state): immediate return to reset values. The in-flight product is discarded and no out_valid pulse follows reset release.
- Operands on a_in/b_in may change freely after the accepting edge.

## Configuration
- KA16_OPCNT_EN defined:
  - op_count port exists.
  - It increments by 1 on each output handshake and wraps 0xFFFF→0x0000.
  - It resets to 0.
- Undefined: port and counter are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package ka_pkg holds:
  - the state enum type (IDLE, LO, HI, MID, DONE)
  - constants KA16_N=16 and KA16_H=8
  - a function for the overlap placement of three (2H-1)-bit terms into 2N-1 bits
- One sub-module, clmul8: combinational H×H carry-less multiplier, output 2H-1 bits. It is instantiated exactly once and shared across LO/HI/MID.

## Test plan
- a=0x0001, b=0x0001 → p_out=0x00000001, out_valid 3 cycles after accept.
- a=0xFFFF, b=0xFFFF → p_out=0x55555555 (all middle-term carries cancel).
- a=0x8000, b=0x8000 → 0x40000000. a=0x0100, b=0x0100 → 0x00010000. a=0x0003, b=0x0003 → 0x00000005.
- Backpressure: out_ready=0 for 10 cycles after out_valid → p_out stable, in_ready=0, second in_valid ignored. Then out_ready=1 together with in_valid → back-to-back accept, next result 4 cycles later.
- rst_n pulsed low during HI → out_valid=0, in_ready=1 immediately. After release, a fresh a=0x1234, b=0x0001 → 0x00001234.
- With KA16_OPCNT_EN: 3 completed products → op_count=3. Preload to 0xFFFF via 65535 ops (or force) and one more → 0x0000.
